fwd_hazard_unit: RTL and testbench

// - Next-generation forwarding block for the 5-stage pipeline. It generalises the 3-input forward mux to NUM_SRC operands.
// - Tracks in-flight destination tags internally (EX/MEM/WB/RET) and computes forward selects in ID, registered into EX.
// - Detects load-use hazards and drives the ID stall/EX bubble; sits between ID/EX pipe register and ALU inputs.

---
 rtl/fwd_hazard_unit_pkg.sv | 33 +++
 rtl/fwd_hazard_unit_if.sv | 38 +++
 rtl/fwd_hazard_unit_tag_pipe.sv | 51 +++++
 rtl/fwd_hazard_unit.sv | 127 ++++++++++++
 tb/tb_fwd_hazard_unit.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types for the forwarding / hazard unit.
//   fwd_sel_e : per-operand forward select (RF, MEM, WB, RET)
//   fwd_tag_t : in-flight destination tag carried down EX->MEM->WB->RET
//   fwd_match : does a tag supply the register a source operand reads?
// Optional feature macro used by the top: FWD_PERF_EN.
package fwd_pkg;

  localparam int FWD_REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10,
    FWD_RET = 2'b11
  } fwd_sel_e;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [FWD_REG_AW-1:0] rd;
    logic                  is_load;
  } fwd_tag_t;

  localparam fwd_tag_t FWD_TAG_BUBBLE = '0;

  // x0 is hard-wired zero and must never be forwarded; unused sources never match.
  function automatic logic fwd_match(input fwd_tag_t tag,
                                     input logic [FWD_REG_AW-1:0] rs,
                                     input logic used);
    return tag.valid && tag.we && (tag.rd == rs) && (rs != '0) && used;
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Bus between the pipeline (master) and the forwarding unit (slave).
// Signals: ID instruction fields, flush, EX-side data inputs, and the
// stall / select / operand outputs of the unit.
//
// ID handshake: id_valid offers the ID instruction; it transfers into EX on a
// rising edge only when id_valid & !stall_o & !flush. While stall_o is high
// the master must hold every id_* field stable. flush kills the offer.
interface fwd_hazard_unit_if #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2
);
  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_rs_addr;
  logic [NUM_SRC-1:0]        id_rs_used;
  logic [REG_AW-1:0]         id_rd;
  logic                      id_we;
  logic                      id_is_load;
  logic                      flush;
  logic [NUM_SRC*DATA_W-1:0] ex_rf_data;
  logic [DATA_W-1:0]         mem_result;
  logic [DATA_W-1:0]         wb_result;
  logic                      stall_o;
  logic [NUM_SRC*2-1:0]      ex_fwd_sel;
  logic [NUM_SRC*DATA_W-1:0] ex_opnd;

  modport master (
    output id_valid, id_rs_addr, id_rs_used, id_rd, id_we, id_is_load, flush,
    output ex_rf_data, mem_result, wb_result,
    input  stall_o, ex_fwd_sel, ex_opnd
  );

  modport slave (
    input  id_valid, id_rs_addr, id_rs_used, id_rd, id_we, id_is_load, flush,
    input  ex_rf_data, mem_result, wb_result,
    output stall_o, ex_fwd_sel, ex_opnd
  );
endinterface

// File: rtl/fwd_hazard_unit_tag_pipe.sv
// fwd_tag_pipe: EX->MEM->WB->RET destination-tag shift register.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   ex_tag_i         next EX tag (already a bubble when ID does not advance)
//   wb_result_i      writeback data, latched every cycle as RET data
//   ex/mem/wb/ret_tag_o  current stage tags
//   ret_data_o       previous cycle's writeback data
module fwd_tag_pipe
  import fwd_pkg::*;
#(
  parameter int DATA_W           = 32,
  parameter int RF_WRITE_THROUGH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  fwd_tag_t          ex_tag_i,
  input  logic [DATA_W-1:0] wb_result_i,
  output fwd_tag_t          ex_tag_o,
  output fwd_tag_t          mem_tag_o,
  output fwd_tag_t          wb_tag_o,
  output fwd_tag_t          ret_tag_o,
  output logic [DATA_W-1:0] ret_data_o
);

  fwd_tag_t          ex_q, mem_q, wb_q, ret_q;
  logic [DATA_W-1:0] ret_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q       <= FWD_TAG_BUBBLE;
      mem_q      <= FWD_TAG_BUBBLE;
      wb_q       <= FWD_TAG_BUBBLE;
      ret_q      <= FWD_TAG_BUBBLE;
      ret_data_q <= '0;
    end else begin
      ex_q       <= ex_tag_i;
      mem_q      <= ex_q;
      wb_q       <= mem_q;
      // With a write-through RF the retired write is already visible in the RF.
      ret_q      <= (RF_WRITE_THROUGH != 0) ? FWD_TAG_BUBBLE : wb_q;
      ret_data_q <= wb_result_i;
    end
  end

  assign ex_tag_o   = ex_q;
  assign mem_tag_o  = mem_q;
  assign wb_tag_o   = wb_q;
  assign ret_tag_o  = ret_q;
  assign ret_data_o = ret_data_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding and load-use stall for a 5-stage pipe.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   bus          fwd_hazard_unit_if.slave (ID fields, flush, data in,
//                stall_o / ex_fwd_sel / ex_opnd out)
//   perf_stall_cnt, perf_fwd_cnt  saturating counters, only with FWD_PERF_EN
// Selects are resolved in ID against EX/MEM/WB tags (which will sit in
// MEM/WB/RET when the instruction reaches EX) and registered into EX; the
// operand mux after them is purely combinational.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int DATA_W           = 32,
  parameter int REG_AW           = 5,
  parameter int NUM_SRC          = 2,
  parameter int LOAD_LAT         = 1,
  parameter int RF_WRITE_THROUGH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  fwd_hazard_unit_if.slave   bus
`ifdef FWD_PERF_EN
  ,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_fwd_cnt
`endif
);

  fwd_tag_t             ex_tag, mem_tag, wb_tag, ret_tag, ex_tag_d;
  logic [DATA_W-1:0]    ret_data;
  logic [NUM_SRC*2-1:0] id_sel, ex_fwd_sel_d, ex_fwd_sel_q;
  logic                 hazard, stall, load_ex;

  fwd_tag_pipe #(
    .DATA_W           (DATA_W),
    .RF_WRITE_THROUGH (RF_WRITE_THROUGH)
  ) u_tag_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_tag_i    (ex_tag_d),
    .wb_result_i (bus.wb_result),
    .ex_tag_o    (ex_tag),
    .mem_tag_o   (mem_tag),
    .wb_tag_o    (wb_tag),
    .ret_tag_o   (ret_tag),
    .ret_data_o  (ret_data)
  );

  // Youngest producer wins. A load that would be picked from MEM (or from WB
  // when load data needs two stages) cannot supply data yet, so it stalls.
  always_comb begin
    id_sel = '0;
    hazard = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (fwd_match(ex_tag, bus.id_rs_addr[i*REG_AW +: REG_AW], bus.id_rs_used[i])) begin
        if (ex_tag.is_load) hazard = 1'b1;
        else                id_sel[i*2 +: 2] = FWD_MEM;
      end else if (fwd_match(mem_tag, bus.id_rs_addr[i*REG_AW +: REG_AW], bus.id_rs_used[i])) begin
        if ((LOAD_LAT == 2) && mem_tag.is_load) hazard = 1'b1;
        else                                    id_sel[i*2 +: 2] = FWD_WB;
      end else if ((RF_WRITE_THROUGH == 0) &&
                   fwd_match(wb_tag, bus.id_rs_addr[i*REG_AW +: REG_AW], bus.id_rs_used[i])) begin
        id_sel[i*2 +: 2] = FWD_RET;
      end
    end
  end

  // Flush beats a hazard: the killed ID instruction has nothing to wait for.
  assign stall   = bus.id_valid && !bus.flush && hazard;
  assign load_ex = bus.id_valid && !stall && !bus.flush;

  always_comb begin
    ex_tag_d     = FWD_TAG_BUBBLE;
    ex_fwd_sel_d = '0;
    if (load_ex) begin
      ex_tag_d.valid   = 1'b1;
      ex_tag_d.we      = bus.id_we;
      ex_tag_d.rd      = bus.id_rd;
      ex_tag_d.is_load = bus.id_is_load;
      ex_fwd_sel_d     = id_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_fwd_sel_q <= '0;
    else        ex_fwd_sel_q <= ex_fwd_sel_d;
  end

  always_comb begin
    bus.ex_opnd = bus.ex_rf_data;
    for (int i = 0; i < NUM_SRC; i++) begin
      case (ex_fwd_sel_q[i*2 +: 2])
        FWD_MEM: bus.ex_opnd[i*DATA_W +: DATA_W] = bus.mem_result;
        FWD_WB:  bus.ex_opnd[i*DATA_W +: DATA_W] = bus.wb_result;
        FWD_RET: bus.ex_opnd[i*DATA_W +: DATA_W] = ret_data;
        default: ;
      endcase
    end
  end

  assign bus.stall_o    = stall;
  assign bus.ex_fwd_sel = ex_fwd_sel_q;

  // Tag fields that some parameterisations never look at.
  logic unused_tags;
  assign unused_tags = ^{ret_tag, wb_tag, mem_tag};

`ifdef FWD_PERF_EN
  logic [31:0] perf_stall_q, perf_fwd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_fwd_q   <= '0;
    end else begin
      if (stall && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
      // Each EX instruction occupies EX for exactly one cycle.
      if (ex_tag.valid && (|ex_fwd_sel_q) && (perf_fwd_q != '1))
        perf_fwd_q <= perf_fwd_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_fwd_cnt   = perf_fwd_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit. u_dut uses the default configuration
// (LOAD_LAT=1, write-through RF); u_ret uses LOAD_LAT=2 with RET forwarding.
// Each DUT is driven in its own phase; the idle one sees id_valid=0.
module tb_fwd_hazard_unit;

  localparam logic [63:0] RF_DATA = 64'h2222_2222_1111_1111;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  fwd_hazard_unit_if #(.DATA_W(32), .REG_AW(5), .NUM_SRC(2)) ia ();
  fwd_hazard_unit_if #(.DATA_W(32), .REG_AW(5), .NUM_SRC(2)) ib ();

`ifdef FWD_PERF_EN
  logic [31:0] a_stall_cnt, a_fwd_cnt, b_stall_cnt, b_fwd_cnt;
`endif

  fwd_hazard_unit #(
    .DATA_W(32), .REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1), .RF_WRITE_THROUGH(1)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ia)
`ifdef FWD_PERF_EN
    ,
    .perf_stall_cnt (a_stall_cnt),
    .perf_fwd_cnt   (a_fwd_cnt)
`endif
  );

  fwd_hazard_unit #(
    .DATA_W(32), .REG_AW(5), .NUM_SRC(2), .LOAD_LAT(2), .RF_WRITE_THROUGH(0)
  ) u_ret (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ib)
`ifdef FWD_PERF_EN
    ,
    .perf_stall_cnt (b_stall_cnt),
    .perf_fwd_cnt   (b_fwd_cnt)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input bit tgt, input logic v, input logic [4:0] rs0,
                        input logic [4:0] rs1, input logic [1:0] used,
                        input logic [4:0] rd, input logic we, input logic ld);
    if (!tgt) begin
      ia.id_valid = v; ia.id_rs_addr = {rs1, rs0}; ia.id_rs_used = used;
      ia.id_rd = rd; ia.id_we = we; ia.id_is_load = ld;
    end else begin
      ib.id_valid = v; ib.id_rs_addr = {rs1, rs0}; ib.id_rs_used = used;
      ib.id_rd = rd; ib.id_we = we; ib.id_is_load = ld;
    end
  endtask

  task automatic set_data(input logic [31:0] wb);
    ia.ex_rf_data = RF_DATA;        ib.ex_rf_data = RF_DATA;
    ia.mem_result = 32'h0000_00A5;  ib.mem_result = 32'h0000_00A5;
    ia.wb_result  = wb;             ib.wb_result  = wb;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ia.flush = 1'b0;
    ib.flush = 1'b0;
    set_id(0, 0, 0, 0, 2'b00, 0, 0, 0);
    set_id(1, 0, 0, 0, 2'b00, 0, 0, 0);
    set_data(32'hDEAD_BEEF);
    repeat (2) cycle();

    // Reset state
    chk("rst_a_stall", {63'd0, ia.stall_o}, 64'd0);
    chk("rst_a_sel",   {60'd0, ia.ex_fwd_sel}, 64'd0);
    chk("rst_a_opnd",  ia.ex_opnd, RF_DATA);
    chk("rst_b_stall", {63'd0, ib.stall_o}, 64'd0);
    chk("rst_b_sel",   {60'd0, ib.ex_fwd_sel}, 64'd0);
    chk("rst_b_opnd",  ib.ex_opnd, RF_DATA);
    rst_n = 1'b1;

    // EX->EX forwarding: add x5 ; add x6,x5,x5
    set_id(0, 1, 1, 2, 2'b11, 5, 1, 0);
    #1 chk("exex_i1_stall", {63'd0, ia.stall_o}, 64'd0);
    cycle();
    set_id(0, 1, 5, 5, 2'b11, 6, 1, 0);
    #1 chk("exex_i2_stall", {63'd0, ia.stall_o}, 64'd0);
    cycle();
    chk("exex_sel",  {60'd0, ia.ex_fwd_sel}, 64'h5);
    chk("exex_opnd", ia.ex_opnd, 64'h0000_00A5_0000_00A5);

    // Double hazard: I3 writes x5 again, I4 reads x5 -> newest (MEM) wins
    set_id(0, 1, 1, 1, 2'b11, 5, 1, 0);
    cycle();
    set_id(0, 1, 5, 0, 2'b01, 9, 1, 0);
    #1 chk("dbl_stall", {63'd0, ia.stall_o}, 64'd0);
    cycle();
    chk("dbl_sel",  {60'd0, ia.ex_fwd_sel}, 64'h1);
    chk("dbl_opnd", ia.ex_opnd, 64'h2222_2222_0000_00A5);

    // Load-use: lw x7 ; add x8,x7,x0
    set_id(0, 1, 1, 0, 2'b01, 7, 1, 1);
    cycle();
    set_id(0, 1, 7, 0, 2'b11, 8, 1, 0);
    #1 chk("lu_stall_on", {63'd0, ia.stall_o}, 64'd1);
    cycle();
    chk("lu_bubble_sel", {60'd0, ia.ex_fwd_sel}, 64'd0);
    chk("lu_stall_off",  {63'd0, ia.stall_o}, 64'd0);
    cycle();
    chk("lu_sel",  {60'd0, ia.ex_fwd_sel}, 64'h2);
    chk("lu_opnd", ia.ex_opnd, 64'h2222_2222_DEAD_BEEF);

    // x0 is never forwarded
    set_id(0, 1, 1, 1, 2'b11, 0, 1, 0);
    cycle();
    set_id(0, 1, 0, 0, 2'b11, 3, 1, 0);
    #1 chk("x0_stall", {63'd0, ia.stall_o}, 64'd0);
    cycle();
    chk("x0_sel", {60'd0, ia.ex_fwd_sel}, 64'd0);

    // Load rd matches only unused sources -> no stall, no forward
    set_id(0, 1, 1, 1, 2'b11, 10, 1, 1);
    cycle();
    set_id(0, 1, 10, 10, 2'b00, 4, 1, 0);
    #1 chk("unused_stall", {63'd0, ia.stall_o}, 64'd0);
    cycle();
    chk("unused_sel", {60'd0, ia.ex_fwd_sel}, 64'd0);

    // Flush during load-use stall
    set_id(0, 1, 1, 1, 2'b11, 11, 1, 1);
    cycle();
    set_id(0, 1, 11, 0, 2'b01, 12, 1, 0);
    #1 chk("fl_stall_pre", {63'd0, ia.stall_o}, 64'd1);
    ia.flush = 1'b1;
    #1 chk("fl_stall_kill", {63'd0, ia.stall_o}, 64'd0);
    cycle();
    ia.flush = 1'b0;
    chk("fl_ex_sel", {60'd0, ia.ex_fwd_sel}, 64'd0);
    // x12 writer was killed (no forward); lw x11 now in MEM -> WB select
    set_id(0, 1, 12, 11, 2'b11, 13, 1, 0);
    #1 chk("fl_after_stall", {63'd0, ia.stall_o}, 64'd0);
    cycle();
    chk("fl_after_sel",  {60'd0, ia.ex_fwd_sel}, 64'h8);
    chk("fl_after_opnd", ia.ex_opnd, 64'hDEAD_BEEF_1111_1111);

    // Flush clears a select that would otherwise be MEM
    set_id(0, 1, 13, 0, 2'b01, 14, 1, 0);
    ia.flush = 1'b1;
    cycle();
    ia.flush = 1'b0;
    chk("fl_clr_sel", {60'd0, ia.ex_fwd_sel}, 64'd0);

    // Writer three ahead with write-through RF -> read RF
    set_id(0, 1, 1, 1, 2'b11, 15, 1, 0);
    cycle();
    set_id(0, 1, 1, 1, 2'b11, 21, 1, 0);
    repeat (2) cycle();
    set_id(0, 1, 15, 15, 2'b11, 16, 1, 0);
    cycle();
    chk("wt_sel", {60'd0, ia.ex_fwd_sel}, 64'd0);

`ifdef FWD_PERF_EN
    chk("perf_stall", {32'd0, a_stall_cnt}, 64'd1);
    chk("perf_fwd",   {32'd0, a_fwd_cnt},   64'd4);
`endif

    // Reset mid-run while a load-use stall is pending
    set_id(0, 1, 1, 1, 2'b11, 14, 1, 1);
    cycle();
    set_id(0, 1, 14, 0, 2'b01, 17, 1, 0);
    #1 chk("mr_stall_pre", {63'd0, ia.stall_o}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_stall", {63'd0, ia.stall_o}, 64'd0);
    chk("mr_sel",   {60'd0, ia.ex_fwd_sel}, 64'd0);
    chk("mr_opnd",  ia.ex_opnd, RF_DATA);
`ifdef FWD_PERF_EN
    chk("mr_perf_stall", {32'd0, a_stall_cnt}, 64'd0);
    chk("mr_perf_fwd",   {32'd0, a_fwd_cnt},   64'd0);
`endif
    cycle();
    rst_n = 1'b1;
    #1 chk("mr_first_stall", {63'd0, ia.stall_o}, 64'd0);
    cycle();
    chk("mr_first_sel", {60'd0, ia.ex_fwd_sel}, 64'd0);
    set_id(0, 0, 0, 0, 2'b00, 0, 0, 0);

    // RET forwarding (u_ret): writer x20, two fillers, reader
    set_id(1, 1, 1, 1, 2'b11, 20, 1, 0);
    cycle();
    set_id(1, 1, 1, 1, 2'b11, 21, 1, 0);
    repeat (2) cycle();
    set_id(1, 1, 20, 20, 2'b11, 16, 1, 0);
    #1 chk("ret_stall", {63'd0, ib.stall_o}, 64'd0);
    cycle();
    // New WB data must not leak in: RET holds the value latched last edge.
    set_data(32'h1234_5678);
    #1;
    chk("ret_sel",  {60'd0, ib.ex_fwd_sel}, 64'hF);
    chk("ret_opnd", ib.ex_opnd, 64'hDEAD_BEEF_DEAD_BEEF);
    set_data(32'hDEAD_BEEF);

    // Load-use with LOAD_LAT=2: two stall cycles, then RET select
    set_id(1, 1, 1, 1, 2'b11, 22, 1, 1);
    cycle();
    set_id(1, 1, 22, 0, 2'b01, 23, 1, 0);
    #1 chk("l2_stall_1", {63'd0, ib.stall_o}, 64'd1);
    cycle();
    chk("l2_stall_2", {63'd0, ib.stall_o}, 64'd1);
    chk("l2_sel_b1",  {60'd0, ib.ex_fwd_sel}, 64'd0);
    cycle();
    chk("l2_stall_3", {63'd0, ib.stall_o}, 64'd0);
    chk("l2_sel_b2",  {60'd0, ib.ex_fwd_sel}, 64'd0);
    cycle();
    chk("l2_sel",  {60'd0, ib.ex_fwd_sel}, 64'h3);
    chk("l2_opnd", ib.ex_opnd, 64'h2222_2222_DEAD_BEEF);
    set_id(1, 0, 0, 0, 2'b00, 0, 0, 0);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
